// File: rtl/ft_recovery_ctrl_pkg.sv
// Shared types and default parameters for the dual-core recovery sequencer.
package ft_pkg;

  typedef enum logic [2:0] {
    RUN,
    HALT,
    COPY,
    RESTART,
    FATAL
  } ft_rec_state_e;

  localparam int FT_ERRCNT_W         = 8;
  localparam int FT_NREGS_DEF        = 32;
  localparam int FT_DRAIN_CYCLES_DEF = 4;
  localparam int FT_MAX_RETRIES_DEF  = 3;
  localparam int FT_CLEAN_CYCLES_DEF = 1024;

endpackage

// File: rtl/ft_recovery_ctrl_if.sv
// Signal bundle between the recovery sequencer and the SoC / dual-core pair.
interface ft_recovery_ctrl_if
  import ft_pkg::*;
#(
  parameter int NREGS = FT_NREGS_DEF
) ();

  logic                       fetch_enable_i;
  logic                       error_i;
  logic [31:0]                pc_checkpoint_i;
  logic                       fetch_enable_o;
  logic                       rf_copy_we_o;
  logic [$clog2(NREGS)-1:0]   rf_copy_addr_o;
  logic                       restart_o;
  logic [31:0]                boot_addr_o;
  logic                       recovering_o;
  logic                       fatal_o;
  logic [FT_ERRCNT_W-1:0]     error_count_o;

  modport master (
    input  fetch_enable_i, error_i, pc_checkpoint_i,
    output fetch_enable_o, rf_copy_we_o, rf_copy_addr_o, restart_o,
           boot_addr_o, recovering_o, fatal_o, error_count_o
  );

  modport slave (
    output fetch_enable_i, error_i, pc_checkpoint_i,
    input  fetch_enable_o, rf_copy_we_o, rf_copy_addr_o, restart_o,
           boot_addr_o, recovering_o, fatal_o, error_count_o
  );

endinterface

// File: rtl/ft_recovery_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module ft_sat_counter
  import ft_pkg::*;
#(
  parameter int WIDTH = FT_ERRCNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (clr_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != {WIDTH{1'b1}})) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Recovery sequencer: halt, drain, copy core 0 regfile into core 1, restart.
//   RUN     | normal operation, fetch follows the SoC enable
//   HALT    | fetch held off while the pipelines drain
//   COPY    | register copy, addresses 1..NREGS-1
//   RESTART | one-cycle restart pulse to both cores
//   FATAL   | too many retries, parked until reset
module ft_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int NREGS        = FT_NREGS_DEF,
  parameter int DRAIN_CYCLES = FT_DRAIN_CYCLES_DEF,
  parameter int MAX_RETRIES  = FT_MAX_RETRIES_DEF,
  parameter int CLEAN_CYCLES = FT_CLEAN_CYCLES_DEF
) (
  input logic                clk_i,
  input logic                rst_i,
  ft_recovery_ctrl_if.master bus
);

  localparam int AW = $clog2(NREGS);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int CW = $clog2(CLEAN_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(NREGS - 1);
  localparam logic [DW-1:0] DRAIN_LOAD  = DW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] CLEAN_LAST  = CW'(CLEAN_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  ft_rec_state_e           state_q, state_d;
  logic                    err_q;
  logic                    accept;
  logic [DW-1:0]           drain_q, drain_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    we_q, we_d;
  logic                    restart_q, restart_d;
  logic                    fe_q, fe_d;
  logic [31:0]             boot_q, boot_d;
  logic                    rec_q, fatal_q;
  logic [CW-1:0]           clean_q, clean_d;
  logic                    clean_done;
  logic [RW-1:0]           retry_cnt;
  logic [FT_ERRCNT_W-1:0]  err_cnt;

  assign accept = (state_q == RUN) && bus.error_i && !err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      err_q     <= 1'b0;
      drain_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      restart_q <= 1'b0;
      fe_q      <= 1'b0;
      boot_q    <= '0;
      rec_q     <= 1'b0;
      fatal_q   <= 1'b0;
      clean_q   <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= bus.error_i;
      drain_q   <= drain_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      restart_q <= restart_d;
      fe_q      <= fe_d;
      boot_q    <= boot_d;
      rec_q     <= (state_d inside {HALT, COPY, RESTART});
      fatal_q   <= (state_d == FATAL);
      clean_q   <= clean_d;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    addr_d     = '0;
    we_d       = 1'b0;
    restart_d  = 1'b0;
    fe_d       = 1'b0;
    boot_d     = boot_q;
    clean_d    = clean_q;
    clean_done = 1'b0;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          clean_d = '0;
          boot_d  = bus.pc_checkpoint_i;
          if (retry_cnt + RW'(1) == RETRY_LIMIT) begin
            state_d = FATAL;
          end else begin
            state_d = HALT;
            drain_d = DRAIN_LOAD;
          end
        end else begin
          fe_d = bus.fetch_enable_i;
          if (bus.fetch_enable_i) begin
            if (clean_q == CLEAN_LAST) begin
              clean_d    = '0;
              clean_done = 1'b1;
            end else begin
              clean_d = clean_q + CW'(1);
            end
          end
        end
      end
      HALT: begin
        if (drain_q == '0) begin
          state_d = COPY;
          we_d    = 1'b1;
          addr_d  = AW'(1);
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      COPY: begin
        if (addr_q == LAST_ADDR) begin
          state_d   = RESTART;
          restart_d = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = addr_q + AW'(1);
        end
      end
      RESTART: state_d = RUN;
      FATAL:   state_d = FATAL;
      default: state_d = RUN;
    endcase
  end

  ft_sat_counter #(.WIDTH(FT_ERRCNT_W)) u_err_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (accept),
    .clr_i   (1'b0),
    .count_o (err_cnt)
  );

  // An edge in the same cycle as window completion suppresses the clear.
  ft_sat_counter #(.WIDTH(RW)) u_retry_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (accept),
    .clr_i   (clean_done),
    .count_o (retry_cnt)
  );

  assign bus.fetch_enable_o = fe_q;
  assign bus.rf_copy_we_o   = we_q;
  assign bus.rf_copy_addr_o = addr_q;
  assign bus.restart_o      = restart_q;
  assign bus.boot_addr_o    = boot_q;
  assign bus.recovering_o   = rec_q;
  assign bus.fatal_o        = fatal_q;
  assign bus.error_count_o  = err_cnt;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Bench for ft_recovery_ctrl: vector table, hand sequences, random run vs timeline model.
module tb_ft_recovery_ctrl;

  localparam int NREGS = 32;
  localparam int D     = 4;
  localparam int MAXR  = 3;
  localparam int CLEAN = 1024;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  ft_recovery_ctrl_if #(.NREGS(NREGS)) bus ();

  ft_recovery_ctrl #(
    .NREGS(NREGS), .DRAIN_CYCLES(D), .MAX_RETRIES(MAXR), .CLEAN_CYCLES(CLEAN)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit fe, input bit err, input logic [31:0] pc);
    bus.fetch_enable_i  = fe;
    bus.error_i         = err;
    bus.pc_checkpoint_i = pc;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".fe"},    32'(bus.fetch_enable_o), 0);
    check({tag, ".we"},    32'(bus.rf_copy_we_o),   0);
    check({tag, ".addr"},  32'(bus.rf_copy_addr_o), 0);
    check({tag, ".rst"},   32'(bus.restart_o),      0);
    check({tag, ".boot"},  bus.boot_addr_o,         0);
    check({tag, ".rec"},   32'(bus.recovering_o),   0);
    check({tag, ".fatal"}, 32'(bus.fatal_o),        0);
    check({tag, ".cnt"},   32'(bus.error_count_o),  0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0);
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      cyc();
    end
  endtask

  task automatic raise_err(input logic [31:0] pc);
    drive(1'b1, 1'b1, pc);
    cyc();
    drive(1'b1, 1'b0, pc);
  endtask

  // Recovery must last exactly drain + copy + restart cycles after the accepting edge.
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (bus.recovering_o && k < 100) begin
      cyc();
      k++;
    end
    check({tag, ".rec_len"}, k, D + NREGS);
  endtask

  // Timeline model: position counts cycles since the accepted edge.
  bit          m_prev, m_fatal, m_fe;
  int          m_pos, m_cnt, m_retry, m_clean;
  logic [31:0] m_boot;

  task automatic m_reset();
    m_prev = 0; m_fatal = 0; m_fe = 0;
    m_pos = 0; m_cnt = 0; m_retry = 0; m_clean = 0;
    m_boot = 0;
  endtask

  task automatic m_step(input bit fe, input bit err, input logic [31:0] pc);
    bit rise;
    rise   = err && !m_prev;
    m_prev = err;
    m_fe   = 0;
    if (m_fatal) return;
    if (m_pos == 0) begin
      if (rise) begin
        m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_retry = m_retry + 1;
        m_clean = 0;
        m_boot  = pc;
        if (m_retry == MAXR) m_fatal = 1;
        else m_pos = 1;
      end else begin
        m_fe = fe;
        if (fe) begin
          m_clean = m_clean + 1;
          if (m_clean == CLEAN) begin
            m_clean = 0;
            m_retry = 0;
          end
        end
      end
    end else if (m_pos == D + NREGS) begin
      m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
    end
  endtask

  task automatic check_model(input string tag);
    bit we;
    we = (m_pos > D) && (m_pos < D + NREGS);
    check({tag, ".fe"},    32'(bus.fetch_enable_o), 32'(m_fe));
    check({tag, ".we"},    32'(bus.rf_copy_we_o),   32'(we));
    check({tag, ".addr"},  32'(bus.rf_copy_addr_o), we ? m_pos - D : 0);
    check({tag, ".rst"},   32'(bus.restart_o),      32'(m_pos == D + NREGS));
    check({tag, ".rec"},   32'(bus.recovering_o),   32'(m_pos != 0));
    check({tag, ".fatal"}, 32'(bus.fatal_o),        32'(m_fatal));
    check({tag, ".cnt"},   32'(bus.error_count_o),  m_cnt);
    check({tag, ".boot"},  bus.boot_addr_o,         m_boot);
  endtask

  typedef struct {
    bit          fe;
    bit          err;
    logic [31:0] pc;
    int          n;
    bit          e_fe;
    bit          e_we;
    int          e_a0;
    int          e_as;
    bit          e_rs;
    bit          e_rec;
    bit          e_fat;
    int          e_cnt;
    logic [31:0] e_boot;
  } vec_t;

  function automatic vec_t mk(bit fe, bit err, logic [31:0] pc, int n, bit efe, bit ewe,
                              int a0, int as, bit ers, bit erec, bit efat, int ecnt,
                              logic [31:0] eboot);
    vec_t v;
    v.fe = fe; v.err = err; v.pc = pc; v.n = n;
    v.e_fe = efe; v.e_we = ewe; v.e_a0 = a0; v.e_as = as; v.e_rs = ers;
    v.e_rec = erec; v.e_fat = efat; v.e_cnt = ecnt; v.e_boot = eboot;
    return v;
  endfunction

  vec_t vt[$];
  int   rates[4] = '{20, 150, 700, 2000};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          fe_r, err_r;
    logic [31:0] pc_r;

    //          fe err pc       n   fe we a0 as rs rec fat cnt boot
    vt.push_back(mk(1, 0, 32'h0,   1,  1, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 32'h0,   5,  1, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 1, 32'h40,  1,  0, 0, 0, 0, 0, 1, 0, 1, 32'h40));
    vt.push_back(mk(1, 1, 32'h40,  2,  0, 0, 0, 0, 0, 1, 0, 1, 32'h40));
    vt.push_back(mk(1, 0, 32'h40,  1,  0, 0, 0, 0, 0, 1, 0, 1, 32'h40));
    vt.push_back(mk(1, 0, 32'h0,  31,  0, 1, 1, 1, 0, 1, 0, 1, 32'h40));
    vt.push_back(mk(1, 0, 32'h0,   1,  0, 0, 0, 0, 1, 1, 0, 1, 32'h40));
    vt.push_back(mk(1, 0, 32'h0,   1,  0, 0, 0, 0, 0, 0, 0, 1, 32'h40));
    vt.push_back(mk(1, 0, 32'h0,   3,  1, 0, 0, 0, 0, 0, 0, 1, 32'h40));
    vt.push_back(mk(1, 1, 32'h80,  1,  0, 0, 0, 0, 0, 1, 0, 2, 32'h80));
    vt.push_back(mk(1, 0, 32'h80,  3,  0, 0, 0, 0, 0, 1, 0, 2, 32'h80));
    vt.push_back(mk(1, 0, 32'h0,  10,  0, 1, 1, 1, 0, 1, 0, 2, 32'h80));
    vt.push_back(mk(1, 1, 32'h999, 1,  0, 1, 11, 0, 0, 1, 0, 2, 32'h80));
    vt.push_back(mk(1, 0, 32'h0,  20,  0, 1, 12, 1, 0, 1, 0, 2, 32'h80));
    vt.push_back(mk(1, 0, 32'h0,   1,  0, 0, 0, 0, 1, 1, 0, 2, 32'h80));
    vt.push_back(mk(1, 0, 32'h0,   1,  0, 0, 0, 0, 0, 0, 0, 2, 32'h80));
    vt.push_back(mk(1, 0, 32'h0,   2,  1, 0, 0, 0, 0, 0, 0, 2, 32'h80));
    vt.push_back(mk(1, 1, 32'h100, 1,  0, 0, 0, 0, 0, 0, 1, 3, 32'h100));
    vt.push_back(mk(1, 0, 32'h0,   3,  0, 0, 0, 0, 0, 0, 1, 3, 32'h100));
    vt.push_back(mk(1, 1, 32'h200, 1,  0, 0, 0, 0, 0, 0, 1, 3, 32'h100));
    vt.push_back(mk(1, 0, 32'h0,   5,  0, 0, 0, 0, 0, 0, 1, 3, 32'h100));

    // Reset state, then the vector table from reset.
    drive(1'b1, 1'b0, 32'h0);
    rst_i = 1'b1;
    cyc();
    cyc();
    check_zero("reset");
    rst_i = 1'b0;
    foreach (vt[i]) begin
      for (int c = 0; c < vt[i].n; c++) begin
        drive(vt[i].fe, vt[i].err, vt[i].pc);
        cyc();
        check($sformatf("v%0d.fe", i),    32'(bus.fetch_enable_o), 32'(vt[i].e_fe));
        check($sformatf("v%0d.we", i),    32'(bus.rf_copy_we_o),   32'(vt[i].e_we));
        check($sformatf("v%0d.addr", i),  32'(bus.rf_copy_addr_o), vt[i].e_a0 + c * vt[i].e_as);
        check($sformatf("v%0d.rst", i),   32'(bus.restart_o),      32'(vt[i].e_rs));
        check($sformatf("v%0d.rec", i),   32'(bus.recovering_o),   32'(vt[i].e_rec));
        check($sformatf("v%0d.fatal", i), 32'(bus.fatal_o),        32'(vt[i].e_fat));
        check($sformatf("v%0d.cnt", i),   32'(bus.error_count_o),  vt[i].e_cnt);
        check($sformatf("v%0d.boot", i),  bus.boot_addr_o,         vt[i].e_boot);
      end
    end

    // Reset in the middle of a copy, then a fresh error must not escalate.
    do_reset();
    idle(2);
    raise_err(32'h10);
    wait_done("mid1");
    raise_err(32'h20);
    begin
      int k;
      k = 0;
      while (bus.rf_copy_addr_o != 10 && k < 80) begin
        cyc();
        k++;
      end
    end
    check("mid.reach_addr10", 32'(bus.rf_copy_addr_o), 10);
    rst_i = 1'b1;
    #1;
    check_zero("async_rst");
    cyc();
    rst_i = 1'b0;
    idle(1);
    check("mid.run_fe", 32'(bus.fetch_enable_o), 1);
    check("mid.run_rec", 32'(bus.recovering_o), 0);
    raise_err(32'h30);
    check("mid.after_rec", 32'(bus.recovering_o), 1);
    check("mid.after_fatal", 32'(bus.fatal_o), 0);
    check("mid.after_cnt", 32'(bus.error_count_o), 1);
    check("mid.after_boot", bus.boot_addr_o, 32'h30);
    wait_done("mid2");

    // Full clean window clears the retry count.
    do_reset();
    raise_err(32'h1);
    wait_done("cw1");
    raise_err(32'h2);
    wait_done("cw2");
    idle(CLEAN);
    raise_err(32'h3);
    check("cw3.fatal", 32'(bus.fatal_o), 0);
    check("cw3.rec", 32'(bus.recovering_o), 1);
    wait_done("cw3");
    raise_err(32'h4);
    check("cw4.fatal", 32'(bus.fatal_o), 0);
    wait_done("cw4");
    check("cw.cnt", 32'(bus.error_count_o), 4);

    // Edge on the cycle the window would complete: edge wins, third retry is fatal.
    do_reset();
    raise_err(32'h5);
    wait_done("pr1");
    raise_err(32'h6);
    wait_done("pr2");
    idle(CLEAN - 1);
    raise_err(32'h7);
    check("pr.fatal", 32'(bus.fatal_o), 1);
    check("pr.fe", 32'(bus.fetch_enable_o), 0);
    check("pr.rec", 32'(bus.recovering_o), 0);
    idle(40);
    check("pr.fatal_hold", 32'(bus.fatal_o), 1);
    check("pr.no_copy", 32'(bus.rf_copy_we_o), 0);
    check("pr.no_restart", 32'(bus.restart_o), 0);

    // Randomized episodes against the timeline model.
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      m_reset();
      err_r = 0;
      for (int c = 0; c < 3000; c++) begin
        fe_r = ($urandom_range(0, 7) != 0);
        if (!err_r) err_r = ($urandom_range(1, rates[ep]) == 1);
        else        err_r = ($urandom_range(0, 1) == 1);
        pc_r = $urandom;
        drive(fe_r, err_r, pc_r);
        cyc();
        m_step(fe_r, err_r, pc_r);
        check_model($sformatf("rnd%0d.%0d", ep, c));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
